fetch_seq_ctrl: RTL and testbench
=================================

// Module: fetch_seq_ctrl
// PURPOSE
//  Sequencer for the instruction-fetch stage PC. Picks next-PC source (reset/exception vector,
//  interrupt vector, popped PC, jump target, PC+1) and tracks two-word I-type fetches.
//  Defers interrupts to instruction boundaries and runs the multi-cycle interrupt-entry
//  sequence (flush, push return PC, vector). Sits between the PC register and the hazard/EX/MEM redirect sources.
// PARAMETERS
//  RST_VEC      32'd32  PC loaded on reset and on exception
//  INT_VEC      32'd0   PC loaded on interrupt entry
//  PUSH_CYCLES  2       cycles int_push_req is held during interrupt entry (>=1)
//  ITYPE_OP     4'd8    opcode[15:12] marking a two-word (immediate) instruction
// PORTS
//  clk           in   1   single clock; all state updates on posedge clk
//  reset         in   1   synchronous, active-high
//  pc_cur        in   32  current PC register value
//  instr_op      in   4   opcode of word fetched at pc_cur
//  stall         in   1   hazard stall: freeze PC
//  exception     in   1   redirect to RST_VEC
//  interrupt     in   1   external interrupt pulse
//  set_int       in   1   software interrupt pulse (SET_INT)
//  pop_pc        in   1   redirect to pc_pop_value (RET/RTI)
//  pc_pop_value  in   32  popped PC
//  jmp_sgn       in   1   redirect to pc_jmp_value
//  pc_jmp_value  in   32  jump target
//  pc_next       out  32  value to load into PC
//  pc_we         out  1   PC write enable
//  flush_if      out  1   squash the word currently in IF/ID
//  imm_phase     out  1   word at pc_cur is the immediate of the preceding I-type
//  int_pending   out  1   latched, not-yet-taken interrupt
//  int_push_req  out  1   request to push int_ret_pc onto the stack
//  int_ret_pc    out  32  return PC captured at interrupt entry
//  int_ack       out  1   one-cycle pulse when the PC is loaded with INT_VEC
// BEHAVIOUR
//  States: RUN, IMM, INT_PUSH, INT_VEC. Outputs are combinational from state+inputs; state,
//  int_pending, push counter and int_ret_pc are registered.
//  reset=1: next state RUN; int_pending, counter and int_ret_pc cleared.
//   During reset: pc_next=RST_VEC, pc_we=1, flush_if=1, all other outputs 0.
//  Priority, every state: reset > exception > stall > pop_pc > jmp_sgn > interrupt entry > sequential.
//  exception: pc_next=RST_VEC, pc_we=1, flush_if=1, next RUN. Overrides stall.
//   Aborts INT_PUSH/INT_VEC and clears int_pending.
//  stall (no reset/exception): pc_we=0, flush_if=0, state/counter hold; pulses still latch.
//  pop_pc / jmp_sgn in RUN or IMM: pc_next=pop/jmp value, pc_we=1, flush_if=1, next RUN.
//   Ignored in INT_PUSH/INT_VEC.
//  int_pending: set on posedge where interrupt|set_int=1; cleared on entry to INT_PUSH
//   or on exception. A pulse in the same cycle as the clear is kept (set wins).
//  RUN, no redirect, int_pending=1: interrupt entry. pc_we=0, flush_if=1, int_ret_pc<=pc_cur,
//   counter<=PUSH_CYCLES-1, next INT_PUSH.
//  RUN, no redirect, no interrupt: pc_next=pc_cur+1, pc_we=1.
//   Next IMM if instr_op==ITYPE_OP, else RUN.
//  IMM: imm_phase=1. pc_next=pc_cur+1, pc_we=1, next RUN. Interrupt never taken in IMM.
//   The instruction boundary is after the immediate.
//  INT_PUSH: int_push_req=1, pc_we=0, flush_if=1.
//   Counter decrements each unstalled cycle; at 0, next INT_VEC.
//  INT_VEC: pc_next=INT_VEC, pc_we=1, flush_if=1, int_ack=1, next RUN.
//  Width: pc_cur+1 wraps modulo 2^32 (32'hFFFFFFFF -> 0), no flag.
//  Latency: pulse at cycle t -> earliest int_ack at t+2+PUSH_CYCLES (RUN, no stall/redirect).
// STRUCTURE
//  Package fetch_ctrl_pkg: state encoding, ITYPE_OP, default RST_VEC/INT_VEC.
//   Shared with decode and the hazard unit.
//  Sub-module fetch_pc_mux: combinational priority mux producing pc_next/pc_we/flush_if from
//   state and request lines. The FSM, int_pending latch and counter stay in fetch_seq_ctrl.
// TESTING
//  1. reset 2 cycles, pc_cur=0x20, op=0x1 -> pc_next=32 during reset.
//     Then pc_next=0x21, pc_we=1, state RUN.
//  2. RUN pc_cur=0x40, op=0x8 -> pc_next=0x41, next cycle imm_phase=1.
//     An interrupt pulse then is deferred: int_pending=1 and no flush until after IMM.
//  3. interrupt pulse at pc_cur=0x50, PUSH_CYCLES=2 -> int_ret_pc=0x50.
//     int_push_req high 2 cycles, then pc_next=0, int_ack=1 for 1 cycle, int_pending=0.
//  4. jmp_sgn=1 (0x100) and pop_pc=1 (0x200) in the same cycle -> pc_next=0x200, flush_if=1.
//     With stall=1 in the same cycle -> pc_we=0 and no state change.
//  5. exception during INT_PUSH -> pc_next=32, pc_we=1, int_push_req drops next cycle.
//     int_ack is never asserted and int_pending=0.
//  6. pc_cur=32'hFFFFFFFF sequential -> pc_next=0; set_int held 3 cycles while stall=1
//     -> exactly one interrupt entry after stall drops.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared fetch-sequencer types and default vectors
package fetch_ctrl_pkg;

  localparam logic [31:0] RST_VEC_DEF  = 32'd32;
  localparam logic [31:0] INT_VEC_DEF  = 32'd0;
  localparam logic [3:0]  ITYPE_OP_DEF = 4'd8;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_IMM,
    ST_INT_PUSH,
    ST_INT_VEC
  } fetch_state_e;

  // Which rule won the priority mux this cycle; the FSM steps on this.
  typedef enum logic [2:0] {
    SEL_RST,
    SEL_HOLD,
    SEL_POP,
    SEL_JMP,
    SEL_INT_ENTRY,
    SEL_SEQ,
    SEL_PUSH,
    SEL_VEC
  } pc_sel_e;

endpackage

// File: rtl/fetch_seq_ctrl_if.sv
// rtl/fetch_seq_ctrl_if.sv - PC-side request and redirect bundle of the fetch sequencer
interface fetch_seq_ctrl_if;
  logic [31:0] pc_cur;
  logic [3:0]  instr_op;
  logic        stall;
  logic        exception;
  logic        interrupt;
  logic        set_int;
  logic        pop_pc;
  logic [31:0] pc_pop_value;
  logic        jmp_sgn;
  logic [31:0] pc_jmp_value;
  logic [31:0] pc_next;
  logic        pc_we;
  logic        flush_if;
  logic        imm_phase;
  logic        int_pending;
  logic        int_push_req;
  logic [31:0] int_ret_pc;
  logic        int_ack;

  modport master (
    output pc_cur, instr_op, stall, exception, interrupt, set_int,
           pop_pc, pc_pop_value, jmp_sgn, pc_jmp_value,
    input  pc_next, pc_we, flush_if, imm_phase, int_pending,
           int_push_req, int_ret_pc, int_ack
  );

  modport slave (
    input  pc_cur, instr_op, stall, exception, interrupt, set_int,
           pop_pc, pc_pop_value, jmp_sgn, pc_jmp_value,
    output pc_next, pc_we, flush_if, imm_phase, int_pending,
           int_push_req, int_ret_pc, int_ack
  );
endinterface

// File: rtl/fetch_pc_mux.sv
// rtl/fetch_pc_mux.sv - priority mux choosing next PC, write enable and IF flush
module fetch_pc_mux
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RST_VEC = RST_VEC_DEF,
  parameter logic [31:0] INT_VEC = INT_VEC_DEF
) (
  input  fetch_state_e state,
  input  logic         reset,
  input  logic         exception,
  input  logic         stall,
  input  logic         pop_pc,
  input  logic         jmp_sgn,
  input  logic         int_pending,
  input  logic [31:0]  pc_cur,
  input  logic [31:0]  pc_pop_value,
  input  logic [31:0]  pc_jmp_value,
  output logic [31:0]  pc_next,
  output logic         pc_we,
  output logic         flush_if,
  output pc_sel_e      sel
);

  always_comb begin
    pc_next  = pc_cur + 32'd1;
    pc_we    = 1'b0;
    flush_if = 1'b0;
    sel      = SEL_SEQ;
    if (reset || exception) begin
      pc_next  = RST_VEC;
      pc_we    = 1'b1;
      flush_if = 1'b1;
      sel      = SEL_RST;
    end else if (stall) begin
      pc_next = pc_cur;
      sel     = SEL_HOLD;
    end else begin
      case (state)
        ST_RUN, ST_IMM: begin
          if (pop_pc) begin
            pc_next  = pc_pop_value;
            pc_we    = 1'b1;
            flush_if = 1'b1;
            sel      = SEL_POP;
          end else if (jmp_sgn) begin
            pc_next  = pc_jmp_value;
            pc_we    = 1'b1;
            flush_if = 1'b1;
            sel      = SEL_JMP;
          end else if (state == ST_RUN && int_pending) begin
            // Boundary reached: squash IF but keep PC so it becomes the return address.
            pc_next  = pc_cur;
            flush_if = 1'b1;
            sel      = SEL_INT_ENTRY;
          end else begin
            pc_we = 1'b1;
          end
        end
        ST_INT_PUSH: begin
          pc_next  = pc_cur;
          flush_if = 1'b1;
          sel      = SEL_PUSH;
        end
        ST_INT_VEC: begin
          pc_next  = INT_VEC;
          pc_we    = 1'b1;
          flush_if = 1'b1;
          sel      = SEL_VEC;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// rtl/fetch_seq_ctrl.sv - fetch PC sequencer with I-type tracking and interrupt entry
module fetch_seq_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RST_VEC     = RST_VEC_DEF,
  parameter logic [31:0] INT_VEC     = INT_VEC_DEF,
  parameter int          PUSH_CYCLES = 2,
  parameter logic [3:0]  ITYPE_OP    = ITYPE_OP_DEF
) (
  input logic             clk,
  input logic             reset,
  fetch_seq_ctrl_if.slave bus
);

  localparam int            CW       = (PUSH_CYCLES > 1) ? $clog2(PUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(PUSH_CYCLES - 1);

  fetch_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [31:0]   ret_q, ret_d;
  pc_sel_e       sel;

  fetch_pc_mux #(
    .RST_VEC (RST_VEC),
    .INT_VEC (INT_VEC)
  ) u_mux (
    .state        (state_q),
    .reset        (reset),
    .exception    (bus.exception),
    .stall        (bus.stall),
    .pop_pc       (bus.pop_pc),
    .jmp_sgn      (bus.jmp_sgn),
    .int_pending  (pend_q),
    .pc_cur       (bus.pc_cur),
    .pc_pop_value (bus.pc_pop_value),
    .pc_jmp_value (bus.pc_jmp_value),
    .pc_next      (bus.pc_next),
    .pc_we        (bus.pc_we),
    .flush_if     (bus.flush_if),
    .sel          (sel)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ret_d   = ret_q;
    case (sel)
      SEL_RST, SEL_POP, SEL_JMP, SEL_VEC: state_d = ST_RUN;
      SEL_INT_ENTRY: begin
        state_d = ST_INT_PUSH;
        cnt_d   = CNT_INIT;
        ret_d   = bus.pc_cur;
      end
      SEL_SEQ: begin
        state_d = (state_q == ST_RUN && bus.instr_op == ITYPE_OP) ? ST_IMM : ST_RUN;
      end
      SEL_PUSH: begin
        if (cnt_q == '0) state_d = ST_INT_VEC;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: ;
    endcase
    // A new pulse in the clearing cycle survives so it is taken on the next boundary.
    pend_d = bus.interrupt | bus.set_int |
             (pend_q & ~(sel == SEL_RST || sel == SEL_INT_ENTRY));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ret_q   <= ret_d;
    end
  end

  assign bus.imm_phase    = (state_q == ST_IMM) && !reset;
  assign bus.int_push_req = (state_q == ST_INT_PUSH) && !reset;
  assign bus.int_ack      = (sel == SEL_VEC);
  assign bus.int_pending  = pend_q && !reset;
  assign bus.int_ret_pc   = reset ? 32'd0 : ret_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb/tb_fetch_seq_ctrl.sv - self-checking bench for fetch_seq_ctrl
module tb_fetch_seq_ctrl;

  localparam logic [31:0] RST_V = 32'd32;
  localparam logic [31:0] INT_V = 32'd0;
  localparam int          PUSH  = 2;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fetch_seq_ctrl_if b ();

  fetch_seq_ctrl #(
    .RST_VEC     (RST_V),
    .INT_VEC     (INT_V),
    .PUSH_CYCLES (PUSH),
    .ITYPE_OP    (4'd8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: instruction-level view; m_push counts remaining push cycles.
  bit          m_imm, m_vec, m_pend;
  int          m_push;
  logic [31:0] m_ret;

  always @(negedge clk) begin
    logic [31:0] e_pc;
    bit          e_we, e_fl, e_ack, pulse;
    pulse = b.interrupt | b.set_int;
    e_pc  = b.pc_cur + 32'd1;
    e_we  = 1'b0;
    e_fl  = 1'b0;
    e_ack = 1'b0;
    if (reset) begin
      e_pc = RST_V; e_we = 1'b1; e_fl = 1'b1;
      chk("m_imm_phase", {31'd0, b.imm_phase}, 32'd0);
      chk("m_push_req", {31'd0, b.int_push_req}, 32'd0);
      chk("m_pending", {31'd0, b.int_pending}, 32'd0);
      chk("m_ret_pc", b.int_ret_pc, 32'd0);
      m_imm = 0; m_vec = 0; m_pend = 0; m_push = 0; m_ret = 0;
    end else begin
      chk("m_imm_phase", {31'd0, b.imm_phase}, {31'd0, m_imm});
      chk("m_push_req", {31'd0, b.int_push_req}, {31'd0, m_push > 0});
      chk("m_pending", {31'd0, b.int_pending}, {31'd0, m_pend});
      chk("m_ret_pc", b.int_ret_pc, m_ret);
      if (b.exception) begin
        e_pc = RST_V; e_we = 1'b1; e_fl = 1'b1;
        m_imm = 0; m_vec = 0; m_push = 0; m_pend = pulse;
      end else if (b.stall) begin
        m_pend = m_pend | pulse;
      end else if (m_push > 0) begin
        e_fl = 1'b1;
        m_push--;
        if (m_push == 0) m_vec = 1;
        m_pend = m_pend | pulse;
      end else if (m_vec) begin
        e_pc = INT_V; e_we = 1'b1; e_fl = 1'b1; e_ack = 1'b1;
        m_vec = 0;
        m_pend = m_pend | pulse;
      end else if (b.pop_pc || b.jmp_sgn) begin
        e_pc = b.pop_pc ? b.pc_pop_value : b.pc_jmp_value;
        e_we = 1'b1; e_fl = 1'b1;
        m_imm = 0;
        m_pend = m_pend | pulse;
      end else if (!m_imm && m_pend) begin
        e_fl = 1'b1;
        m_ret = b.pc_cur;
        m_push = PUSH;
        m_pend = pulse;
      end else begin
        e_we = 1'b1;
        m_imm = !m_imm && (b.instr_op == 4'd8);
        m_pend = m_pend | pulse;
      end
    end
    chk("m_pc_we", {31'd0, b.pc_we}, {31'd0, e_we});
    chk("m_flush_if", {31'd0, b.flush_if}, {31'd0, e_fl});
    chk("m_int_ack", {31'd0, b.int_ack}, {31'd0, e_ack});
    if (e_we) chk("m_pc_next", b.pc_next, e_pc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int acks;

  initial begin
    reset = 1'b1;
    b.pc_cur = 32'h20; b.instr_op = 4'h1; b.stall = 0; b.exception = 0;
    b.interrupt = 0; b.set_int = 0; b.pop_pc = 0; b.pc_pop_value = 32'h200;
    b.jmp_sgn = 0; b.pc_jmp_value = 32'h100;

    // 1: reset then first sequential step
    @(negedge clk);
    chk("rst_pc_next", b.pc_next, 32'd32);
    chk("rst_pc_we", {31'd0, b.pc_we}, 32'd1);
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("seq_pc_next", b.pc_next, 32'h21);
    chk("seq_pc_we", {31'd0, b.pc_we}, 32'd1);
    tick();

    // 2: I-type fetch defers an interrupt until after the immediate
    b.pc_cur = 32'h40; b.instr_op = 4'h8;
    @(negedge clk);
    chk("itype_pc_next", b.pc_next, 32'h41);
    tick();
    b.pc_cur = 32'h41; b.instr_op = 4'h0; b.interrupt = 1;
    @(negedge clk);
    chk("imm_phase", {31'd0, b.imm_phase}, 32'd1);
    chk("imm_no_flush", {31'd0, b.flush_if}, 32'd0);
    tick();
    b.interrupt = 0; b.pc_cur = 32'h42; b.instr_op = 4'h1;
    @(negedge clk);
    chk("defer_pending", {31'd0, b.int_pending}, 32'd1);
    chk("defer_entry_flush", {31'd0, b.flush_if}, 32'd1);
    tick(); tick(); tick();
    @(negedge clk);
    chk("defer_ack", {31'd0, b.int_ack}, 32'd1);
    tick();

    // 3: full interrupt entry with return PC capture
    b.pc_cur = 32'h4F; b.interrupt = 1;
    tick();
    b.interrupt = 0; b.pc_cur = 32'h50;
    tick();
    @(negedge clk);
    chk("ent_ret_pc", b.int_ret_pc, 32'h50);
    chk("ent_push1", {31'd0, b.int_push_req}, 32'd1);
    tick();
    @(negedge clk);
    chk("ent_push2", {31'd0, b.int_push_req}, 32'd1);
    tick();
    @(negedge clk);
    chk("ent_vec_pc", b.pc_next, 32'd0);
    chk("ent_ack", {31'd0, b.int_ack}, 32'd1);
    tick();
    b.pc_cur = 32'd0;
    @(negedge clk);
    chk("ent_ack_drop", {31'd0, b.int_ack}, 32'd0);
    chk("ent_pending_clr", {31'd0, b.int_pending}, 32'd0);
    tick();

    // 4: pop beats jump; stall beats both
    b.pc_cur = 32'h60; b.jmp_sgn = 1; b.pop_pc = 1; b.stall = 1;
    @(negedge clk);
    chk("stall_we", {31'd0, b.pc_we}, 32'd0);
    tick();
    b.stall = 0;
    @(negedge clk);
    chk("pop_pc_next", b.pc_next, 32'h200);
    chk("pop_flush", {31'd0, b.flush_if}, 32'd1);
    tick();
    b.jmp_sgn = 0; b.pop_pc = 0; b.pc_cur = 32'h200;
    tick();

    // 5: exception aborts interrupt entry
    b.pc_cur = 32'h70; b.set_int = 1;
    tick();
    b.set_int = 0; b.pc_cur = 32'h71;
    tick();
    b.exception = 1; b.stall = 1;
    @(negedge clk);
    chk("exc_pc_next", b.pc_next, 32'd32);
    chk("exc_over_stall", {31'd0, b.pc_we}, 32'd1);
    tick();
    b.exception = 0; b.stall = 0; b.pc_cur = 32'd32;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) chk("exc_push_drop", {31'd0, b.int_push_req}, 32'd0);
      if (b.int_ack) acks++;
      tick();
    end
    chk("exc_no_ack", acks, 0);

    // 6: PC wrap, then a long set_int under stall gives one entry
    b.pc_cur = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("wrap_pc_next", b.pc_next, 32'd0);
    tick();
    b.stall = 1; b.set_int = 1;
    tick(); tick(); tick();
    b.stall = 0; b.set_int = 0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b.int_ack) acks++;
      tick();
    end
    chk("one_entry", acks, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
